// File: rtl/qar_dmem_pkg.sv
// Shared types and constants for the qar_core data-memory controller.
// QAR_DMEM_PARITY_EN widens the SRAM word by one even-parity bit.
package qar_dmem_pkg;

    localparam int QAR_WORD_W     = 32;
    localparam int QAR_WAIT_CNT_W = 4;

`ifdef QAR_DMEM_PARITY_EN
    localparam int QAR_SRAM_W = QAR_WORD_W + 1;
`else
    localparam int QAR_SRAM_W = QAR_WORD_W;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ACCESS = 3'd2,
        RDLAT  = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/qar_dmem_ctrl_parity.sv
// 32-bit even-parity reduce; only present in builds with QAR_DMEM_PARITY_EN.
`ifdef QAR_DMEM_PARITY_EN
module qar_parity32 (
    input  logic [31:0] data,
    output logic        parity
);

    assign parity = ^data;

endmodule
`endif

// File: rtl/qar_dmem_ctrl.sv
// Data-memory slave for qar_core: one request, WAIT_STATES wait cycles, one SRAM access.
// Optional QAR_DMEM_PARITY_EN stores/checks an even-parity bit alongside each word.
module qar_dmem_ctrl
    import qar_dmem_pkg::*;
#(
    parameter int          DMEM_ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int          WAIT_STATES     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_valid,
    input  logic                       mem_we,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    output logic                       mem_ready,
    output logic [31:0]                mem_rdata,
    output logic                       mem_err,
    output logic                       sram_ce,
    output logic                       sram_we,
    output logic [DMEM_ADDR_WIDTH-1:0] sram_addr,
    output logic [QAR_SRAM_W-1:0]      sram_wdata,
    input  logic [QAR_SRAM_W-1:0]      sram_rdata,
    output state_t                     dbg_state
);

    // Handshake: the core holds mem_valid/we/addr/wdata stable until mem_ready
    // pulses; a request is captured only in IDLE and mem_valid is ignored elsewhere.

    state_t                     state, state_nxt;
    logic [QAR_WAIT_CNT_W-1:0]  cnt, cnt_nxt;
    logic                       req_we, we_nxt;
    logic [DMEM_ADDR_WIDTH-1:0] req_idx, idx_nxt;
    logic [QAR_WORD_W-1:0]      req_wdata, wdata_nxt;
    logic                       err_nxt;
    logic [QAR_WORD_W-1:0]      rdata_nxt;
    logic                       access_nxt;
    logic                       par_err;

    logic [31:0]                offset;
    logic [32:0]                span;
    logic                       in_range;
    logic                       req_bad;
    logic [DMEM_ADDR_WIDTH-1:0] word_idx;

    assign offset   = mem_addr - BASE_ADDR;
    assign span     = 33'(4) << DMEM_ADDR_WIDTH;
    assign in_range = (mem_addr >= BASE_ADDR) && ({1'b0, offset} < span);
    assign req_bad  = (mem_addr[1:0] != 2'b00) || !in_range;
    assign word_idx = offset[DMEM_ADDR_WIDTH+1:2];

`ifdef QAR_DMEM_PARITY_EN
    logic wpar, rpar;

    qar_parity32 u_wpar (.data(wdata_nxt), .parity(wpar));
    qar_parity32 u_rpar (.data(sram_rdata[QAR_WORD_W-1:0]), .parity(rpar));

    assign par_err = rpar ^ sram_rdata[QAR_WORD_W];
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we_nxt    = req_we;
        idx_nxt   = req_idx;
        wdata_nxt = req_wdata;
        err_nxt   = 1'b0;
        rdata_nxt = mem_rdata;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    we_nxt    = mem_we;
                    idx_nxt   = word_idx;
                    wdata_nxt = mem_wdata;
                    if (req_bad) begin
                        state_nxt = RESP;
                        err_nxt   = 1'b1;
                        rdata_nxt = '0;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = QAR_WAIT_CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_nxt = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) state_nxt = ACCESS;
                else           cnt_nxt   = cnt - 1'b1;
            end
            ACCESS: state_nxt = req_we ? RESP : RDLAT;
            RDLAT: begin
                state_nxt = RESP;
                rdata_nxt = sram_rdata[QAR_WORD_W-1:0];
                err_nxt   = par_err;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    assign access_nxt = (state_nxt == ACCESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            req_we     <= 1'b0;
            req_idx    <= '0;
            req_wdata  <= '0;
            mem_ready  <= 1'b0;
            mem_err    <= 1'b0;
            mem_rdata  <= '0;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            req_we     <= we_nxt;
            req_idx    <= idx_nxt;
            req_wdata  <= wdata_nxt;
            mem_ready  <= (state_nxt == RESP);
            mem_err    <= err_nxt;
            mem_rdata  <= rdata_nxt;
            sram_ce    <= access_nxt;
            sram_we    <= access_nxt && we_nxt;
            sram_addr  <= access_nxt ? idx_nxt : '0;
`ifdef QAR_DMEM_PARITY_EN
            sram_wdata <= access_nxt ? {wpar, wdata_nxt} : '0;
`else
            sram_wdata <= access_nxt ? wdata_nxt : '0;
`endif
        end
    end

    assign dbg_state = state;

endmodule
